// File: rtl/div_iter.sv
// Iterative 32-bit divider: restoring division, one quotient bit per clock.
// Returns {remainder, quotient} with signed (DIV) or unsigned (DIVU) semantics.
module div_iter (
   input  logic        clk,
   input  logic        resetn,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DIVZERO = 2'd1,
      ST_ON      = 2'd2,
      ST_END     = 2'd3
   } state_t;

   state_t      state, state_n;
   logic [4:0]  cnt, cnt_n;
   logic [31:0] rem, rem_n;
   logic [31:0] quo, quo_n;      // dividend bits shift out, quotient bits shift in
   logic [31:0] dvs, dvs_n;
   logic        is_signed, is_signed_n;
   logic        sign1, sign1_n;
   logic        sign2, sign2_n;
   logic [63:0] result_n;
   logic        ready_n;

   // Operand magnitudes; |-2^31| stays 32'h80000000 as an unsigned value.
   logic [31:0] abs1, abs2;
   assign abs1 = (signed_div_i && opdata1_i[31]) ? (32'd0 - opdata1_i) : opdata1_i;
   assign abs2 = (signed_div_i && opdata2_i[31]) ? (32'd0 - opdata2_i) : opdata2_i;

   // One restoring step. rem < dvs always holds, so 33 bits cover the trial.
   logic [32:0] rem_sh, trial;
   logic        step_ge;
   logic [31:0] step_rem, step_quo;
   assign rem_sh   = {rem, quo[31]};
   assign trial    = rem_sh - {1'b0, dvs};
   assign step_ge  = ~trial[32];
   assign step_rem = step_ge ? trial[31:0] : rem_sh[31:0];
   assign step_quo = {quo[30:0], step_ge};

   logic [31:0] fix_quo, fix_rem;
   assign fix_quo = (is_signed && (sign1 ^ sign2)) ? (32'd0 - step_quo) : step_quo;
   assign fix_rem = (is_signed && sign1)           ? (32'd0 - step_rem) : step_rem;

   // NOTE: every register, operands included, is cleared by reset so an
   // aborted operation leaves nothing behind; there is no memory array here.
   // NOTE: sequential state uses non-blocking assignments only, so all
   // registers update together from the values present before the edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         cnt       <= 5'd0;
         rem       <= 32'd0;
         quo       <= 32'd0;
         dvs       <= 32'd0;
         is_signed <= 1'b0;
         sign1     <= 1'b0;
         sign2     <= 1'b0;
         result_o  <= 64'd0;
         ready_o   <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         rem       <= rem_n;
         quo       <= quo_n;
         dvs       <= dvs_n;
         is_signed <= is_signed_n;
         sign1     <= sign1_n;
         sign2     <= sign2_n;
         result_o  <= result_n;
         ready_o   <= ready_n;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a variable unassigned and infer a latch.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      rem_n       = rem;
      quo_n       = quo;
      dvs_n       = dvs;
      is_signed_n = is_signed;
      sign1_n     = sign1;
      sign2_n     = sign2;
      result_n    = result_o;
      ready_n     = ready_o;

      unique case (state)
         ST_IDLE: begin
            result_n = 64'd0;
            ready_n  = 1'b0;
            if (start_i && !annul_i) begin
               if (opdata2_i == 32'd0) begin
                  state_n = ST_DIVZERO;
               end else begin
                  state_n     = ST_ON;
                  cnt_n       = 5'd0;
                  rem_n       = 32'd0;
                  quo_n       = abs1;
                  dvs_n       = abs2;
                  is_signed_n = signed_div_i;
                  sign1_n     = opdata1_i[31];
                  sign2_n     = opdata2_i[31];
               end
            end
         end

         ST_DIVZERO: begin
            result_n = 64'd0;
            if (annul_i) begin
               state_n = ST_IDLE;
               ready_n = 1'b0;
            end else begin
               state_n = ST_END;
               ready_n = 1'b1;
            end
         end

         ST_ON: begin
            if (annul_i) begin
               state_n  = ST_IDLE;
               ready_n  = 1'b0;
               result_n = 64'd0;
            end else begin
               rem_n = step_rem;
               quo_n = step_quo;
               if (cnt == 5'd31) begin
                  state_n  = ST_END;
                  ready_n  = 1'b1;
                  result_n = {fix_rem, fix_quo};
               end else begin
                  cnt_n = cnt + 5'd1;
               end
            end
         end

         ST_END: begin
            // Result holds while the requester keeps start_i high; annul_i is ignored.
            if (!start_i) begin
               state_n  = ST_IDLE;
               ready_n  = 1'b0;
               result_n = 64'd0;
            end
         end

         default: begin
            state_n  = ST_IDLE;
            ready_n  = 1'b0;
            result_n = 64'd0;
         end
      endcase
   end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 The block SHALL have no parameters; the datapath is fixed at 32-bit operands and a 64-bit result.
REQ-002 clk  input  1  Rising-edge clock for all state.
REQ-003 resetn  input  1  Reset, asynchronous and active-low; one clock; reset is asynchronous and active-low.
REQ-004 signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i.
REQ-005 opdata1_i  input  32  Dividend; sampled with start_i.
REQ-006 opdata2_i  input  32  Divisor; sampled with start_i.
REQ-007 start_i  input  1  Request. The initiator holds it high, with operands stable, until ready_o rises.
REQ-008 annul_i  input  1  Abort the operation in flight.
REQ-009 result_o  output  64  {remainder[63:32], quotient[31:0]}. This maps to HI/LO for the EX stage.
REQ-010 ready_o  output  1  Result valid. It is high only in END.

Function
REQ-011 FSM states SHALL be IDLE, DIVZERO, ON and END, held in registers; result_o and ready_o SHALL be registered outputs.
REQ-012 IDLE, start_i=1, annul_i=0, opdata2_i=0: next state SHALL be DIVZERO.
REQ-013 IDLE, start_i=1, annul_i=0, opdata2_i!=0: next state SHALL be ON.
  - Latch |dividend| and |divisor| when signed, raw values when unsigned.
  - Latch signed_div_i and both operand sign bits.
  - Clear the iteration counter to 0 and the partial remainder to 0.
REQ-014 IDLE with start_i=0 SHALL stay in IDLE with ready_o=0 and result_o=0.
REQ-015 DIVZERO SHALL go to END on the next edge with result_o=64'h0.
REQ-016 ON SHALL perform one restoring-division step per cycle, MSB first, for exactly 32 cycles (counter 0..31).
  - Shift {rem, dividend} left by 1.
  - Form a 33-bit trial subtraction of the divisor.
  - If the result is non-negative, keep the difference and set the quotient bit to 1.
  - Otherwise, restore and set the quotient bit to 0.
REQ-017 After step 31, the next edge SHALL enter END with ready_o=1 and result_o loaded, applying sign correction when signed.
  - Quotient is negated when sign1 XOR sign2.
  - Remainder is negated when sign1 (remainder takes the dividend's sign).
REQ-018 Latency: an edge sampling start_i in IDLE with a nonzero divisor SHALL produce ready_o=1 after exactly 33 edges; a zero divisor SHALL produce ready_o=1 after 2 edges.
REQ-019 In END, ready_o and result_o SHALL hold while start_i=1. When start_i=0, the next edge SHALL go to IDLE with ready_o=0 and result_o=0.
REQ-020 annul_i=1 in DIVZERO or ON SHALL force IDLE on the next edge with ready_o=0; no result is produced. annul_i SHALL be ignored in END.
REQ-021 annul_i=1 in IDLE at the same time as start_i=1 SHALL keep the block in IDLE (annul wins).
REQ-022 Signed -2^31 / -1 SHALL return quotient 32'h80000000 (two's-complement wrap) and remainder 0, with no exception.
REQ-023 Signed -2^31 as dividend or divisor SHALL be handled through a 32-bit unsigned magnitude (|-2^31| = 32'h80000000).
REQ-024 The operand inputs SHALL NOT affect state after sampling; changes during ON SHALL be ignored.

Reset
REQ-025 resetn=0 SHALL immediately, without waiting for a clock edge, force IDLE, ready_o=0, result_o=0, counter=0 and all latched operands to 0.
REQ-026 Reset asserted in ON or END SHALL discard the operation; after release, the block SHALL accept a new start_i on the first edge.
REQ-027 start_i held high across reset release SHALL be sampled on the first edge after release, as a fresh request.

Verification
REQ-028 DIVU 7/2, start held: ready_o rises 33 edges after sampling, result_o=64'h00000001_00000003; start dropped -> ready_o=0 next edge.
REQ-029 DIV -7/2 (32'hFFFFFFF9 / 2): result_o=64'hFFFFFFFF_FFFFFFFD; DIV 7/-2: result_o=64'h00000001_FFFFFFFD.
REQ-030 DIVU 32'hFFFFFFFF/1 -> 64'h00000000_FFFFFFFF; DIV 32'h80000000/32'hFFFFFFFF -> 64'h00000000_80000000.
REQ-031 Divisor 0, either signedness -> ready_o=1 two edges after sampling, result_o=64'h0.
REQ-032 annul_i pulsed at step 10 of ON -> IDLE next edge, ready_o never rises; a following DIVU 100/7 returns 64'h00000002_0000000E.
REQ-033 resetn pulsed low mid-ON (asynchronously, between edges) -> ready_o=0 and result_o=0 immediately; a later request completes with correct latency.
